div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative 32-bit MIPS divider, radix-2 restoring. Handles DIV (signed) and DIVU (unsigned).
- Sits in EX beside the ALU and is the producer of the HI/LO register file's write port.
- Quotient goes to LO, remainder goes to HI.
- EX stalls while the unit is busy. MEM/WB forwards hi_o/lo_o to the HI/LO register on the cycle ready_o=1.

Parameters:
DATA_W, 32, operand width; also the iteration count.
CNT_W, 6, width of the iteration counter (must hold 0..DATA_W).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start_i  in  1  request a division; held high by EX until ready_o is seen.
annul_i  in  1  cancel an in-flight operation (branch flush/exception).
signed_i  in  1  1=DIV, 0=DIVU; sampled at accept.
dividend_i  in  DATA_W  rs operand; sampled at accept.
divisor_i  in  DATA_W  rt operand; sampled at accept.
hi_o  out  DATA_W  remainder.
lo_o  out  DATA_W  quotient.
ready_o  out  1  result valid; doubles as HI/LO write enable.
busy_o  out  1  stall request to the pipeline control.

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, hi_o=0, lo_o=0, ready_o=0, busy_o=0, internal datapath regs=0.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - Accept when start_i=1 && annul_i=0.
  - On accept, latch the absolute values of the operands if signed_i, raw values otherwise.
  - Latch the sign flags: qneg = sign(dividend) XOR sign(divisor); rneg = sign(dividend).
  - Next state is DIVZERO if divisor_i==0, else BUSY with cnt=0 and partial remainder=0.
- BUSY:
  - Each cycle, shift {rem, quot} left by 1.
  - Trial-subtract the divisor from the upper DATA_W+1 bits.
  - If the result is non-negative, keep it and set quot[0]=1; otherwise restore and set quot[0]=0.
  - cnt increments each cycle. After the cycle with cnt==DATA_W-1, go to DONE.
- DONE:
  - ready_o=1. hi_o/lo_o hold the sign-corrected result.
  - If signed and qneg: lo_o = two's-complement negation of quot. If signed and rneg: hi_o = negated rem.
  - Stay in DONE while start_i=1. Go to IDLE the cycle after start_i=0; ready_o drops with it.
  - A new start needs at least one IDLE cycle.
- DIVZERO: lasts one cycle, then DONE with hi_o=0 and lo_o=0. MIPS leaves this result undefined; the team defines it as zero.
- busy_o = 1 in DIVZERO and BUSY, and in IDLE when start_i=1 && annul_i=0 (combinational, so the stall starts the same cycle). busy_o=0 in DONE.
- Latency, accept edge to ready_o=1:
  - normal operands: DATA_W+1 cycles (33);
  - divisor zero: 2 cycles.
- annul_i=1 in BUSY or DIVZERO: next state IDLE, ready_o stays 0, hi_o/lo_o unchanged. annul_i in DONE: go to IDLE.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo_o=0x80000000, hi_o=0 (natural wrap, no trap).
- Inputs are ignored outside IDLE; operands changing mid-operation have no effect.
- Async reset mid-operation: immediate return to the reset values; no partial result escapes.
- All width arithmetic is unsigned DATA_W+1 bits; the sign correction is applied only at DONE entry.

Decomposition:
- Shared defines header (same as the rest of the core): RegBus width, ZeroWord, RstEnable, WriteEnable.
- New defines: DivFree/DivByZero/DivOn/DivEnd state encodings, DivResultReady/NotReady, DivStart/DivStop.
- Single module; no sub-module is warranted. The abs/negate helpers are local functions.

Test Plan:
- DIVU 7/2, start held: ready_o rises 33 cycles after accept; lo_o=3, hi_o=1; busy_o=1 throughout BUSY.
- DIV -7/2 (0xFFFFFFF9, 2): lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 7/-2: lo_o=0xFFFFFFFD, hi_o=1.
- DIVU 0xFFFFFFFF/1: lo_o=0xFFFFFFFF, hi_o=0. DIV 0x80000000/0xFFFFFFFF: lo_o=0x80000000, hi_o=0.
- Divisor zero (10/0): ready_o=1 two cycles after accept, hi_o=lo_o=0.
- Pulse annul_i at BUSY cycle 10: unit is IDLE next cycle, ready_o never asserts. A new DIVU 100/7 then gives lo_o=14, hi_o=2.
- Assert rst asynchronously mid-BUSY: all outputs 0 before the next clock edge. Hold start_i in DONE for 5 cycles: ready_o stays 1 with no restart; it drops one cycle after start_i=0.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared constants, state encoding and datapath widths for the iterative divider.
// Imported by the divider and its bus interface.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  localparam int                    REG_BUS_W    = DIV_DATA_W;
  localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
  localparam logic                  RST_ENABLE   = 1'b1;
  localparam logic                  WRITE_ENABLE = 1'b1;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage request/response bundle between pipeline control and the divider.
// master = EX control (drives request), slave = divider (drives result/stall).
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);
  logic              start_i;
  logic              annul_i;
  logic              signed_i;
  logic [DATA_W-1:0] dividend_i;
  logic [DATA_W-1:0] divisor_i;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              ready_o;
  logic              busy_o;

  modport master (
    output start_i, annul_i, signed_i, dividend_i, divisor_i,
    input  hi_o, lo_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, dividend_i, divisor_i,
    output hi_o, lo_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU: LO=quotient, HI=remainder; ready 33 cycles after the accept cycle (2 on /0).
// busy_o stalls EX from the accept cycle until DONE; ready_o holds while start_i stays high.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_e        r_state;
  div_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_divisor;
  logic              r_qneg;
  logic              r_rneg;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic              w_req;
  logic              w_accept;
  logic              w_step;
  logic              w_last;
  logic              w_zero_done;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quot_nxt;

  function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? f_neg(v) : v;
  endfunction

  assign w_req = (bus.start_i == DIV_START) && !bus.annul_i;

  // Upper DATA_W+1 bits of {rem, quot} << 1 against the zero-extended divisor.
  assign w_trial    = {r_rem, r_quot[DATA_W-1]} - {1'b0, r_divisor};
  assign w_rem_nxt  = w_trial[DATA_W] ? {r_rem[DATA_W-2:0], r_quot[DATA_W-1]}
                                      : w_trial[DATA_W-1:0];
  assign w_quot_nxt = {r_quot[DATA_W-2:0], ~w_trial[DATA_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state <= DIV_FREE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    w_zero_done = 1'b0;
    case (r_state)
      DIV_FREE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.divisor_i == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        if (bus.annul_i) begin
          w_state_nxt = DIV_FREE;
        end else begin
          w_zero_done = 1'b1;
          w_state_nxt = DIV_END;
        end
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          w_state_nxt = DIV_FREE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            w_last      = 1'b1;
            w_state_nxt = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (bus.annul_i || (bus.start_i == DIV_STOP)) begin
          w_state_nxt = DIV_FREE;
        end
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_cnt     <= '0;
      r_rem     <= ZERO_WORD;
      r_quot    <= ZERO_WORD;
      r_divisor <= ZERO_WORD;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_hi      <= ZERO_WORD;
      r_lo      <= ZERO_WORD;
    end else begin
      if (w_accept) begin
        r_cnt     <= '0;
        r_rem     <= ZERO_WORD;
        r_quot    <= bus.signed_i ? f_abs(bus.dividend_i) : bus.dividend_i;
        r_divisor <= bus.signed_i ? f_abs(bus.divisor_i) : bus.divisor_i;
        r_qneg    <= bus.signed_i & (bus.dividend_i[DATA_W-1] ^ bus.divisor_i[DATA_W-1]);
        r_rneg    <= bus.signed_i & bus.dividend_i[DATA_W-1];
      end
      if (w_step) begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_rem  <= w_rem_nxt;
        r_quot <= w_quot_nxt;
      end
      // Sign correction happens only here, on the transition into DONE.
      if (w_last) begin
        r_lo <= r_qneg ? f_neg(w_quot_nxt) : w_quot_nxt;
        r_hi <= r_rneg ? f_neg(w_rem_nxt) : w_rem_nxt;
      end
      if (w_zero_done) begin
        r_lo <= ZERO_WORD;
        r_hi <= ZERO_WORD;
      end
    end
  end

  assign bus.hi_o    = r_hi;
  assign bus.lo_o    = r_lo;
  assign bus.ready_o = (r_state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  // Gated by rst so a held start_i cannot raise a stall while the unit is in reset.
  assign bus.busy_o  = (rst != RST_ENABLE) &&
                       ((r_state == DIV_ON) || (r_state == DIV_BY_ZERO) ||
                        ((r_state == DIV_FREE) && w_req));

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit with a queue scoreboard and a ready-edge monitor.
module tb_div_unit;

  logic clk;
  logic rst;

  div_unit_if #(.DATA_W(32)) bus();

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [63:0] sb_q[$];
  logic        prev_rdy = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [63:0] exp_v;
    if (bus.ready_o && !prev_rdy) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_ready: got ready_o=1 expected no result pending");
      end else begin
        exp_v = sb_q.pop_front();
        chk("result_hi", bus.hi_o, exp_v[63:32]);
        chk("result_lo", bus.lo_o, exp_v[31:0]);
      end
    end
    prev_rdy <= bus.ready_o;
  end

  task automatic run_op(input string name, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input int exp_lat, input int hold);
    int   n;
    logic seen;
    logic busy_ok;
    logic hold_ok;
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    sb_q.push_back({exp_hi, exp_lo});
    n       = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    // n counts edges from the accept edge inclusive, i.e. cycles from the accept cycle.
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus.dividend_i = ~a;
        bus.divisor_i  = 32'h0;
        bus.signed_i   = ~sgn;
      end
      if (bus.ready_o) seen = 1'b1;
      else if (!bus.busy_o) busy_ok = 1'b0;
    end
    if (!seen) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s_timeout: got no ready_o in %0d cycles expected ready_o=1", name, n);
    end else begin
      chk({name, "_latency"}, n, exp_lat);
      chk({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
    end
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (!bus.ready_o || bus.busy_o) hold_ok = 1'b0;
    end
    if (hold > 0) chk({name, "_hold_ready"}, {31'b0, hold_ok}, 32'd1);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_ready_drop"}, {31'b0, bus.ready_o}, 32'd0);
  endtask

  initial begin : stim
    logic never_rdy;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.annul_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'h0;
    bus.divisor_i  = 32'h0;
    #12;
    chk("reset_hi", bus.hi_o, 32'h0);
    chk("reset_lo", bus.lo_o, 32'h0);
    chk("reset_ready", {31'b0, bus.ready_o}, 32'd0);
    chk("reset_busy", {31'b0, bus.busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("divu_7_2", 1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 33, 0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 0);

    // Annul after ten BUSY cycles: no result, HI/LO keep the previous values.
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd50;
    bus.divisor_i  = 32'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("annul_ready", {31'b0, bus.ready_o}, 32'd0);
    chk("annul_idle_busy", {31'b0, bus.busy_o}, 32'd0);
    chk("annul_hi_kept", bus.hi_o, 32'd1);
    chk("annul_lo_kept", bus.lo_o, 32'hFFFF_FFFD);
    @(negedge clk);
    bus.annul_i = 1'b0;
    never_rdy = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) never_rdy = 1'b0;
    end
    chk("annul_no_ready", {31'b0, never_rdy}, 32'd1);

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 5);

    // Asynchronous reset in the middle of BUSY, away from any clock edge.
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.signed_i   = 1'b1;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd7;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hi", bus.hi_o, 32'h0);
    chk("arst_lo", bus.lo_o, 32'h0);
    chk("arst_ready", {31'b0, bus.ready_o}, 32'd0);
    chk("arst_busy", {31'b0, bus.busy_o}, 32'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0);
    run_op("divu_10_0", 1'b0, 32'd10, 32'd0, 32'd0, 32'd0, 2, 0);
    run_op("divu_1000_33", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 33, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
